decode_ctrl_pipe: RTL

- Registered successor to the combinational control decoder; sits at the ID/EX boundary of the RV32I core.
- Decodes `instr` into datapath control and holds it in a pipeline register with stall/flush handling.
- Adds halfword loads/stores, illegal-instruction detection, a saturating illegal counter, and a trap FSM for ecall/ebreak/illegal.

---
 rtl/ctrl_pkg.sv | 118 +++++++++++
 rtl/decode_ctrl_pipe_decode.sv | 137 +++++++++++++
 rtl/decode_ctrl_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control encodings for the ID/EX decode pipeline.
// The optional M-extension decode is enabled by defining RV32M_EN.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Branch compare flavour comes from ALUctrl (SLT vs SLTU) on PC_BLT/PC_BGE.
  typedef enum logic [2:0] {
    PC_NEXT = 3'd0,
    PC_JAL  = 3'd1,
    PC_JALR = 3'd2,
    PC_BEQ  = 3'd3,
    PC_BNE  = 3'd4,
    PC_BLT  = 3'd5,
    PC_BGE  = 3'd6
  } pc_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [2:0] {
    AM_W  = 3'd0,
    AM_B  = 3'd1,
    AM_BU = 3'd2,
    AM_H  = 3'd3,
    AM_HU = 3'd4
  } addr_mode_e;

  typedef enum logic [1:0] {
    RES_ALU   = 2'd0,
    RES_MEM   = 2'd1,
    RES_PC4   = 2'd2,
    RES_PCIMM = 2'd3
  } result_src_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_ECALL   = 2'd2,
    TC_EBREAK  = 2'd3
  } trap_cause_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    alu_op_e     alu_ctrl;
    logic        alu_src;
    imm_src_e    imm_src;
    pc_src_e     pc_src;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    addr_mode_e  addr_mode;
    result_src_e result_src;
    logic        mul_en;
    logic [2:0]  mul_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_ctrl:   ALU_ADD,
    alu_src:    1'b0,
    imm_src:    IMM_I,
    pc_src:     PC_NEXT,
    reg_write:  1'b0,
    mem_write:  1'b0,
    mem_read:   1'b0,
    addr_mode:  AM_W,
    result_src: RES_ALU,
    mul_en:     1'b0,
    mul_op:     3'd0
  };

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_decode.sv
// Combinational RV32I control decoder with illegal-instruction detection.
// Defining RV32M_EN adds the M-extension encodings (otherwise they decode as illegal).
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_ecall,
  output logic        is_ebreak
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ctrl      = CTRL_NOP;
    illegal   = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_PCIMM;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.pc_src     = PC_JAL;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.pc_src     = PC_JALR;
        ctrl.result_src = RES_PC4;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        case (f3)
          3'b000:  begin ctrl.pc_src = PC_BEQ; ctrl.alu_ctrl = ALU_SUB;  end
          3'b001:  begin ctrl.pc_src = PC_BNE; ctrl.alu_ctrl = ALU_SUB;  end
          3'b100:  begin ctrl.pc_src = PC_BLT; ctrl.alu_ctrl = ALU_SLT;  end
          3'b101:  begin ctrl.pc_src = PC_BGE; ctrl.alu_ctrl = ALU_SLT;  end
          3'b110:  begin ctrl.pc_src = PC_BLT; ctrl.alu_ctrl = ALU_SLTU; end
          3'b111:  begin ctrl.pc_src = PC_BGE; ctrl.alu_ctrl = ALU_SLTU; end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        case (f3)
          3'b000:  ctrl.addr_mode = AM_B;
          3'b001:  ctrl.addr_mode = AM_H;
          3'b010:  ctrl.addr_mode = AM_W;
          3'b100:  ctrl.addr_mode = AM_BU;
          3'b101:  ctrl.addr_mode = AM_HU;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        case (f3)
          3'b000:  ctrl.addr_mode = AM_B;
          3'b001:  ctrl.addr_mode = AM_H;
          3'b010:  ctrl.addr_mode = AM_W;
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_from_f3(f3, 1'b0);
        // Only the shift immediates carry a funct7 field.
        if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'h20)      ctrl.alu_ctrl = ALU_SRA;
          else if (f7 != 7'h00) illegal = 1'b1;
        end
      end
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        if (f7 == 7'h00) begin
          ctrl.alu_ctrl = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ctrl.alu_ctrl = alu_from_f3(f3, 1'b1);
        end
`ifdef RV32M_EN
        else if (f7 == 7'h01) begin
          ctrl.mul_en = 1'b1;
          ctrl.mul_op = f3;
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end
      OP_FENCE: begin
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OP_SYSTEM: begin
        if (instr[31:7] == 25'd0)                                 is_ecall  = 1'b1;
        else if (instr[31:20] == 12'd1 && instr[19:7] == 13'd0)   is_ebreak = 1'b1;
        else                                                      illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) begin
      ctrl      = CTRL_NOP;
      is_ecall  = 1'b0;
      is_ebreak = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered ID/EX control decode with stall/flush, illegal counter and trap FSM.
// Define RV32M_EN to enable M-extension decode; otherwise MulEn/MulOp are tied to 0.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 trap_ack,
  output logic                 out_valid,
  output logic [3:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [2:0]           ImmSrc,
  output logic [2:0]           PCsrc,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [2:0]           AddrMode,
  output logic [1:0]           ResultSrc,
  output logic                 MulEn,
  output logic [2:0]           MulOp,
  output logic                 illegal,
  output logic                 trap_req,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  ctrl_t       dec_ctrl;
  logic        dec_illegal, dec_ecall, dec_ebreak;

  ctrl_t       ctrl_q, ctrl_d;
  logic        vld_q, vld_d;
  logic        ill_q, ill_d;
  logic        trap_req_q, trap_req_d;
  trap_cause_e cause_q, cause_d;
  state_e      state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic accept;

  instr_decode u_dec (
    .instr     (instr[31:0]),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal),
    .is_ecall  (dec_ecall),
    .is_ebreak (dec_ebreak)
  );

  assign accept = in_valid & ~stall & ~flush & (state_q == ST_RUN);

  always_comb begin
    ctrl_d     = ctrl_q;
    vld_d      = vld_q;
    ill_d      = ill_q;
    trap_req_d = trap_req_q;
    cause_d    = cause_q;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (flush) begin
      ctrl_d = CTRL_NOP;
      vld_d  = 1'b0;
      ill_d  = 1'b0;
    end else if (stall) begin
      // hold every field
    end else if (accept) begin
      ctrl_d = dec_ctrl;
      vld_d  = 1'b1;
      ill_d  = dec_illegal;
    end else begin
      ctrl_d = CTRL_NOP;
      vld_d  = 1'b0;
      ill_d  = 1'b0;
    end

    if (accept && (dec_illegal || dec_ecall || dec_ebreak)) begin
      state_d    = ST_TRAP;
      trap_req_d = 1'b1;
      if (dec_illegal)    cause_d = TC_ILLEGAL;
      else if (dec_ecall) cause_d = TC_ECALL;
      else                cause_d = TC_EBREAK;
    end

    if (accept && dec_illegal && cnt_q != {CNT_WIDTH{1'b1}})
      cnt_d = cnt_q + CNT_WIDTH'(1);

    // Ack is only meaningful in TRAP and is not gated by stall.
    if (state_q == ST_TRAP && trap_ack) begin
      state_d    = ST_RUN;
      trap_req_d = 1'b0;
      cause_d    = TC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_NOP;
      vld_q      <= 1'b0;
      ill_q      <= 1'b0;
      trap_req_q <= 1'b0;
      cause_q    <= TC_NONE;
      state_q    <= ST_RUN;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      vld_q      <= vld_d;
      ill_q      <= ill_d;
      trap_req_q <= trap_req_d;
      cause_q    <= cause_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid     = vld_q;
  assign ALUctrl       = ctrl_q.alu_ctrl;
  assign ALUsrc        = ctrl_q.alu_src;
  assign ImmSrc        = ctrl_q.imm_src;
  assign PCsrc         = ctrl_q.pc_src;
  assign RegWrite      = ctrl_q.reg_write;
  assign MemWrite      = ctrl_q.mem_write;
  assign MemRead       = ctrl_q.mem_read;
  assign AddrMode      = ctrl_q.addr_mode;
  assign ResultSrc     = ctrl_q.result_src;
  assign illegal       = ill_q;
  assign trap_req      = trap_req_q;
  assign trap_cause    = cause_q;
  assign illegal_count = cnt_q;

`ifdef RV32M_EN
  assign MulEn = ctrl_q.mul_en;
  assign MulOp = ctrl_q.mul_op;
`else
  assign MulEn = 1'b0;
  assign MulOp = 3'd0;
`endif

endmodule
